// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-read/multi-write register file.
// Optional same-cycle write-to-read forwarding is enabled by REGFILE_MRNW_BYPASS_EN.
package regfile_pkg;

  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_DEPTH      = 32;
  localparam int RF_ADDR_WIDTH = $clog2(RF_DEPTH);
  localparam int RF_NUM_RD     = 4;
  localparam int RF_NUM_WR     = 2;

  typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;
  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;

  // Width of a write-port index; a single port still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_wr_arbiter.sv
// Per-entry write enable/port select (highest port wins) and busy-bit next state.
// Alloc beats a same-cycle write for the busy bit; entry 0 is masked when ZERO_ENTRY=1.
module rf_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH      = RF_DEPTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NUM_WR     = RF_NUM_WR,
  parameter int ZERO_ENTRY = 1,
  parameter int SEL_W      = sel_width(NUM_WR)
) (
  input  logic [NUM_WR-1:0]                 wr_en,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0] wr_addr,
  input  logic                              alloc_en,
  input  logic [ADDR_WIDTH-1:0]             alloc_addr,
  input  logic [DEPTH-1:0]                  busy,
  output logic [DEPTH-1:0]                  ent_we,
  output logic [DEPTH-1:0][SEL_W-1:0]       ent_sel,
  output logic [DEPTH-1:0]                  busy_nxt
);

  always_comb begin
    // NOTE: every output gets a default before any conditional assignment, so no latch is inferred.
    ent_we   = '0;
    ent_sel  = '0;
    busy_nxt = busy;
    for (int e = 0; e < DEPTH; e++) begin
      // Ascending scan: a later (higher) port overrides the select.
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && (wr_addr[p] == ADDR_WIDTH'(e))) begin
          ent_we[e]  = 1'b1;
          ent_sel[e] = SEL_W'(p);
        end
      end
      if (ent_we[e]) busy_nxt[e] = 1'b0;
      if (alloc_en && (alloc_addr == ADDR_WIDTH'(e))) busy_nxt[e] = 1'b1;
    end
    if (ZERO_ENTRY != 0) begin
      ent_we[0]   = 1'b0;
      busy_nxt[0] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mrnw.sv
// Register file with NUM_RD registered read ports, NUM_WR write ports and a per-entry busy bit.
// Define REGFILE_MRNW_BYPASS_EN to forward same-cycle writes/busy updates to reads.
module regfile_mrnw
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int DEPTH      = RF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NUM_RD     = RF_NUM_RD,
  parameter int NUM_WR     = RF_NUM_WR,
  parameter int ZERO_ENTRY = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_WR-1:0]                 wr_en_i,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_data_i,
  input  logic                              alloc_en_i,
  input  logic [ADDR_WIDTH-1:0]             alloc_addr_i,
  input  logic [NUM_RD-1:0]                 rd_en_i,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data_o,
  output logic [NUM_RD-1:0]                 rd_valid_o,
  output logic [NUM_RD-1:0]                 rd_ready_o
);

  localparam int SEL_W = sel_width(NUM_WR);

  logic [DATA_WIDTH-1:0]             mem [DEPTH];
  logic [DEPTH-1:0]                  busy;
  logic [DEPTH-1:0]                  ent_we;
  logic [DEPTH-1:0][SEL_W-1:0]       ent_sel;
  logic [DEPTH-1:0]                  busy_nxt;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data_nxt;
  logic [NUM_RD-1:0]                 rd_ready_nxt;

  rf_wr_arbiter #(
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_WR    (NUM_WR),
    .ZERO_ENTRY(ZERO_ENTRY),
    .SEL_W     (SEL_W)
  ) u_wr_arbiter (
    .wr_en     (wr_en_i),
    .wr_addr   (wr_addr_i),
    .alloc_en  (alloc_en_i),
    .alloc_addr(alloc_addr_i),
    .busy      (busy),
    .ent_we    (ent_we),
    .ent_sel   (ent_sel),
    .busy_nxt  (busy_nxt)
  );

  // NOTE: the array is reset because the design must read back 0 after rst; this keeps it in flops, not RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) mem[e] <= '0;
      busy <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (ent_we[e]) mem[e] <= wr_data_i[ent_sel[e]];
      end
      busy <= busy_nxt;
    end
  end

  always_comb begin
    rd_data_nxt  = '0;
    rd_ready_nxt = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      rd_data_nxt[r]  = mem[rd_addr_i[r]];
      rd_ready_nxt[r] = ~busy[rd_addr_i[r]];
`ifdef REGFILE_MRNW_BYPASS_EN
      if (ent_we[rd_addr_i[r]]) rd_data_nxt[r] = wr_data_i[ent_sel[rd_addr_i[r]]];
      rd_ready_nxt[r] = ~busy_nxt[rd_addr_i[r]];
`endif
      if ((ZERO_ENTRY != 0) && (rd_addr_i[r] == '0)) begin
        rd_data_nxt[r]  = '0;
        rd_ready_nxt[r] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_o <= '0;
      rd_data_o  <= '0;
      rd_ready_o <= '0;
    end else begin
      rd_valid_o <= rd_en_i;
      for (int r = 0; r < NUM_RD; r++) begin
        if (rd_en_i[r]) begin
          rd_data_o[r]  <= rd_data_nxt[r];
          rd_ready_o[r] <= rd_ready_nxt[r];
        end
      end
    end
  end

endmodule
